// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and oversampling constants.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_mode_t;

   typedef enum logic [2:0] {
      WAIT_HIGH = 3'd0,
      IDLE      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      PARITY    = 3'd4,
      STOP      = 3'd5
   } rx_state_t;

   localparam int unsigned OS_RATE    = 16;
   localparam int unsigned SAMPLE_LO  = 7;
   localparam int unsigned SAMPLE_MID = 8;
   localparam int unsigned SAMPLE_HI  = 9;

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick divider: one-cycle tick every OS_DIV clocks, re-phased by clr.
module uart_os_tick_gen #(
   parameter int unsigned OS_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int unsigned CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(OS_DIV - 1);

   logic [CW-1:0] cnt;

   // Down-counter: a clear lands on terminal count, so the first tick follows
   // the clear immediately and the sample grid is anchored to the start edge.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   always_comb begin
      tick = (cnt == '0);
   end

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 16x oversampling with 3-sample majority vote; reports parity, framing and break.
module uart_rx_os16 #(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned BAUD        = 115_200,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned OS_DIV      = CLK_FREQ / (16 * BAUD)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rx_in,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_data_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_break
);
   import uart_pkg::*;

   localparam parity_mode_t PMODE      = parity_mode_t'(PARITY_MODE[1:0]);
   localparam bit           HAS_PARITY = (PMODE != PAR_NONE);
   localparam logic [3:0]   OS_LO      = 4'(SAMPLE_LO);
   localparam logic [3:0]   OS_MID     = 4'(SAMPLE_MID);
   localparam logic [3:0]   OS_HI      = 4'(SAMPLE_HI);
   localparam logic [3:0]   OS_END     = 4'(OS_RATE - 1);
   localparam logic [2:0]   LAST_DATA  = 3'(DATA_BITS - 1);
   localparam logic [2:0]   LAST_STOP  = 3'(STOP_BITS - 1);

   rx_state_t            state;
   logic                 rx_meta;
   logic                 rxs;
   logic                 rxs_d1;
   logic                 rxs_d2;
   logic                 tick;
   logic                 start_det;
   logic                 maj;
   logic                 at_hi;
   logic                 at_end;
   logic                 exp_par;
   logic [3:0]           os_cnt;
   logic [2:0]           bit_cnt;
   logic [1:0]           samp;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit;
   logic                 stop_ok;
   logic                 any_high;

   uart_os_tick_gen #(
      .OS_DIV(OS_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_det),
      .tick (tick)
   );

   // Reset forces the synchronizer high; the history flops reset low so that
   // stale reset state cannot look like an idle line and re-arm mid-frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d1  <= 1'b0;
         rxs_d2  <= 1'b0;
      end else begin
         rx_meta <= uart_rx_in;
         rxs     <= rx_meta;
         rxs_d1  <= rxs;
         rxs_d2  <= rxs_d1;
      end
   end

   always_comb begin
      start_det = (state == IDLE) && rxs_d1 && !rxs;
      maj       = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
      at_hi     = tick && (os_cnt == OS_HI);
      at_end    = tick && (os_cnt == OS_END);
      exp_par   = (^shift) ^ (PMODE == PAR_ODD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= WAIT_HIGH;
         os_cnt        <= '0;
         bit_cnt       <= '0;
         samp          <= '0;
         shift         <= '0;
         par_bit       <= 1'b0;
         stop_ok       <= 1'b0;
         any_high      <= 1'b0;
         rx_data_out   <= '0;
         rx_data_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_break      <= 1'b0;
      end else begin
         rx_data_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_break      <= 1'b0;

         if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == OS_LO) begin
               samp[0] <= rxs;
            end
            if (os_cnt == OS_MID) begin
               samp[1] <= rxs;
            end
         end

         case (state)
            WAIT_HIGH: begin
               if (rxs && rxs_d1 && rxs_d2) begin
                  state <= IDLE;
               end
            end

            IDLE: begin
               if (start_det) begin
                  os_cnt   <= '0;
                  bit_cnt  <= '0;
                  any_high <= 1'b0;
                  stop_ok  <= 1'b1;
                  state    <= START;
               end
            end

            START: begin
               if (at_hi && maj) begin
                  state <= IDLE;
               end else if (at_end) begin
                  state <= DATA;
               end
            end

            DATA: begin
               if (at_hi) begin
                  shift    <= {maj, shift[DATA_BITS-1:1]};
                  any_high <= any_high | maj;
               end
               if (at_end) begin
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= HAS_PARITY ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end

            PARITY: begin
               if (at_hi) begin
                  par_bit  <= maj;
                  any_high <= any_high | maj;
               end
               if (at_end) begin
                  state <= STOP;
               end
            end

            STOP: begin
               if (at_hi) begin
                  if (bit_cnt == LAST_STOP) begin
                     rx_data_out   <= shift;
                     rx_data_valid <= 1'b1;
                     rx_frame_err  <= !(stop_ok && maj);
                     rx_parity_err <= HAS_PARITY && (par_bit != exp_par);
                     rx_break      <= !(any_high || maj);
                     state         <= maj ? IDLE : WAIT_HIGH;
                  end else begin
                     stop_ok  <= stop_ok & maj;
                     any_high <= any_high | maj;
                  end
               end
               if (at_end) begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end

            default: begin
               state <= WAIT_HIGH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench: 8N1 and 8E1 receivers fed directed and random frames at 64 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_os16;

   localparam int BIT_CLKS = 64;
   localparam int CLK_NS   = 10;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       line_a = 1'b1;
   logic       line_p = 1'b1;
   logic [7:0] data_a, data_p;
   logic       valid_a, fe_a, pe_a, brk_a;
   logic       valid_p, fe_p, pe_p, brk_p;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      logic       brk;
      bit         chk_lat;
      longint     t0;
   } exp_t;

   exp_t q_a[$];
   exp_t q_p[$];
   int   checks = 0;
   int   errors = 0;

   always #(CLK_NS / 2) clk = ~clk;

   uart_rx_os16 #(
      .CLK_FREQ(6_400_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
   ) dut (
      .clk(clk), .rst(rst), .uart_rx_in(line_a), .rx_data_out(data_a), .rx_data_valid(valid_a),
      .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_break(brk_a)
   );

   uart_rx_os16 #(
      .CLK_FREQ(6_400_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)
   ) dut_p (
      .clk(clk), .rst(rst), .uart_rx_in(line_p), .rx_data_out(data_p), .rx_data_valid(valid_p),
      .rx_frame_err(fe_p), .rx_parity_err(pe_p), .rx_break(brk_p)
   );

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input logic [7:0] d,
                          input logic fe, input logic pe, input logic brk);
      longint lat;
      check({tag, "_data"}, d, e.data);
      check({tag, "_frame_err"}, fe, e.fe);
      check({tag, "_parity_err"}, pe, e.pe);
      check({tag, "_break"}, brk, e.brk);
      if (e.chk_lat) begin
         // 2 synchronizer clocks plus nominal 9*64+9*4+1, with +/-2 clk slack
         lat = (longint'($time) - e.t0) / CLK_NS;
         checks++;
         if (lat < 613 || lat > 617) begin
            errors++;
            $display("FAIL %s_latency: got %0d clk, required 613..617 clk", tag, lat);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (valid_a) begin
            if (q_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_valid: got data %0h, required no frame", data_a);
            end else begin
               compare("a", q_a.pop_front(), data_a, fe_a, pe_a, brk_a);
            end
         end else begin
            check("a_flags_idle", {fe_a, pe_a, brk_a}, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (valid_p) begin
            if (q_p.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL p_unexpected_valid: got data %0h, required no frame", data_p);
            end else begin
               compare("p", q_p.pop_front(), data_p, fe_p, pe_p, brk_p);
            end
         end else begin
            check("p_flags_idle", {fe_p, pe_p, brk_p}, 0);
         end
      end
   end

   // Holds a line level for n clocks; callers stay aligned to posedge+1.
   task automatic drive(input int which, input logic v, input int n);
      if (which == 0) line_a = v;
      else            line_p = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int which, input logic [7:0] d, input logic par_flip,
                       input logic stop_v, input int idle, input bit lat);
      exp_t e;
      logic par;
      par       = (^d) ^ par_flip;
      e.data    = d;
      e.fe      = !stop_v;
      e.pe      = (which == 1) && (par != (^d));
      e.brk     = (d == 8'h00) && !stop_v && (which == 0 || par == 1'b0);
      e.chk_lat = lat;
      e.t0      = longint'($time);
      if (which == 0) q_a.push_back(e);
      else            q_p.push_back(e);
      drive(which, 1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive(which, d[i], BIT_CLKS);
      if (which == 1) drive(which, par, BIT_CLKS);
      drive(which, stop_v, BIT_CLKS);
      if (idle > 0) drive(which, 1'b1, idle);
   endtask

   task automatic random_frames(input int which, input int n);
      logic [7:0] d;
      logic       flip, stop_v;
      int         idle;
      for (int k = 0; k < n; k++) begin
         d      = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
         flip   = (which == 1) && ($urandom_range(0, 3) == 0);
         stop_v = ($urandom_range(0, 7) != 0);
         if (!stop_v)                          idle = 16 + $urandom_range(0, 100);
         else if ($urandom_range(0, 1) == 0)   idle = 0;
         else                                  idle = $urandom_range(1, 150);
         send(which, d, flip, stop_v, idle, 1'b0);
      end
   endtask

   initial begin
      exp_t brk_e;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_data_a", data_a, 0);
      check("reset_flags_a", {valid_a, fe_a, pe_a, brk_a}, 0);
      check("reset_data_p", data_p, 0);
      check("reset_flags_p", {valid_p, fe_p, pe_p, brk_p}, 0);
      drive(0, 1'b1, 20);

      send(0, 8'hA5, 1'b0, 1'b1, 200, 1'b1);

      send(0, 8'h5A, 1'b0, 1'b1, 0, 1'b0);
      send(0, 8'hFF, 1'b0, 1'b1, 0, 1'b0);
      send(0, 8'h00, 1'b0, 1'b1, 200, 1'b0);

      drive(0, 1'b0, 8);
      drive(0, 1'b1, 200);
      send(0, 8'h3C, 1'b0, 1'b1, 200, 1'b0);

      send(0, 8'h3C, 1'b0, 1'b0, 100, 1'b0);
      send(0, 8'h81, 1'b0, 1'b1, 200, 1'b0);

      send(1, 8'h07, 1'b1, 1'b1, 200, 1'b0);
      send(1, 8'h07, 1'b0, 1'b1, 200, 1'b0);

      brk_e = '{data: 8'h00, fe: 1'b1, pe: 1'b0, brk: 1'b1, chk_lat: 1'b0, t0: 0};
      q_a.push_back(brk_e);
      drive(0, 1'b0, 12 * BIT_CLKS);
      drive(0, 1'b1, BIT_CLKS);
      send(0, 8'h81, 1'b0, 1'b1, 200, 1'b0);

      // Frame of 0x00 interrupted by reset during its data bits: nothing expected.
      drive(0, 1'b0, BIT_CLKS);
      drive(0, 1'b0, 3 * BIT_CLKS);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_data_a", data_a, 0);
      drive(0, 1'b0, 5 * BIT_CLKS - 1);
      drive(0, 1'b1, BIT_CLKS + 200);
      send(0, 8'hC3, 1'b0, 1'b1, 200, 1'b0);

      random_frames(0, 24);
      random_frames(1, 20);

      for (int i = 0; i < 2000 && (q_a.size() != 0 || q_p.size() != 0); i++) @(posedge clk);
      check("queue_a_drained", q_a.size(), 0);
      check("queue_p_drained", q_p.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
